// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: mm:ss BCD countdown decremented on synchronised C_1Hz rising edges.
// Define SEVEN_SEG_EN to add the seg3..seg0 decoders with 1 Hz blink in DONE.
module countdown_timer_bcd #(
  parameter int SYNC_STAGES    = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        C_50Mhz,
  input  logic        rst_n,
  input  logic        C_1Hz,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [15:0] preset,
  output logic [15:0] bcd,
  output logic [1:0]  state_o,
  output logic        done,
  output logic        alarm
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0]  seg3,
  output logic [6:0]  seg2,
  output logic [6:0]  seg1,
  output logic [6:0]  seg0
`endif
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] PAUSED = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;

  if (SYNC_STAGES < 2 || (SEG_ACTIVE_LOW != 0 && SEG_ACTIVE_LOW != 1)) begin : g_bad_param
    $error("countdown_timer_bcd: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tick;
  logic [15:0]            pre_s;
  logic [15:0]            bcd_n;
  logic [1:0]             st_n;
  logic                   done_n;

  function automatic logic [15:0] sanitize(input logic [15:0] p);
    sanitize = {p[15:12] > 4'd5 ? 4'd5 : p[15:12], p[11:8] > 4'd9 ? 4'd9 : p[11:8],
                p[7:4]   > 4'd5 ? 4'd5 : p[7:4],   p[3:0]  > 4'd9 ? 4'd9 : p[3:0]};
  endfunction

  // Borrow ripples up while every lower digit was zero; min10 saturates at 0.
  function automatic logic [15:0] dec_bcd(input logic [15:0] b);
    logic z0, z1, z2;
    z0 = b[3:0] == 4'd0;
    z1 = z0 && b[7:4] == 4'd0;
    z2 = z1 && b[11:8] == 4'd0;
    dec_bcd[3:0]   = z0 ? 4'd9 : b[3:0] - 4'd1;
    dec_bcd[7:4]   = !z0 ? b[7:4] : (b[7:4] == 4'd0 ? 4'd5 : b[7:4] - 4'd1);
    dec_bcd[11:8]  = !z1 ? b[11:8] : (b[11:8] == 4'd0 ? 4'd9 : b[11:8] - 4'd1);
    dec_bcd[15:12] = !z2 ? b[15:12] : (b[15:12] == 4'd0 ? 4'd0 : b[15:12] - 4'd1);
  endfunction

  always_ff @(posedge C_50Mhz or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], C_1Hz};
      prev <= sync[SYNC_STAGES-1];
    end

  assign tick  = sync[SYNC_STAGES-1] & ~prev;
  assign pre_s = sanitize(preset);

  // Priority clear > start > pause > tick; start in RUN is a no-op and does not mask pause.
  always_comb begin
    st_n   = state_o;
    bcd_n  = bcd;
    done_n = 1'b0;
    if (clear) begin
      st_n  = IDLE;
      bcd_n = pre_s;
    end else if (start && state_o == PAUSED) begin
      st_n = RUN;
    end else if (start && state_o != RUN) begin
      st_n   = pre_s == 16'h0000 ? DONE : RUN;
      bcd_n  = pre_s;
      done_n = pre_s == 16'h0000;
    end else if (pause && state_o == RUN) begin
      st_n = PAUSED;
    end else if (tick && state_o == RUN) begin
      bcd_n  = dec_bcd(bcd);
      st_n   = bcd == 16'h0001 ? DONE : RUN;
      done_n = bcd == 16'h0001;
    end else if (state_o == IDLE) begin
      bcd_n = pre_s;
    end
  end

  always_ff @(posedge C_50Mhz or negedge rst_n)
    if (!rst_n) begin
      state_o <= IDLE;
      bcd     <= 16'h0000;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_o <= st_n;
      bcd     <= bcd_n;
      done    <= done_n;
      alarm   <= st_n == DONE;
    end

`ifdef SEVEN_SEG_EN
  logic disp_on;
  logic blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_out(input logic [3:0] d, input logic blk);
    logic [6:0] pat;
    pat     = blk ? 7'h00 : seg7(d);
    seg_out = SEG_ACTIVE_LOW != 0 ? ~pat : pat;
  endfunction

  // Displays stay dark until the first clock after reset so reset shows blank, not 0000.
  always_ff @(posedge C_50Mhz or negedge rst_n)
    if (!rst_n) disp_on <= 1'b0;
    else        disp_on <= 1'b1;

  assign blank = ~disp_on | (state_o == DONE & ~sync[SYNC_STAGES-1]);
  assign seg3  = seg_out(bcd[15:12], blank);
  assign seg2  = seg_out(bcd[11:8], blank);
  assign seg1  = seg_out(bcd[7:4], blank);
  assign seg0  = seg_out(bcd[3:0], blank);
`endif
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: directed and random checks of countdown_timer_bcd against a seconds-based model.
module tb_countdown_timer_bcd;
  logic        clk = 1'b0, rst_n = 1'b0, c1hz = 1'b0;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [15:0] bcd;
  logic [1:0]  state_o;
  logic        done, alarm;
  int n_vec = 0, n_err = 0, done_cnt = 0;
  int m_secs = 0, m_st = 0;
  bit m_done = 1'b0;
  bit [2:0] hist = 3'b000;

  always #10 clk = ~clk;

  countdown_timer_bcd dut (
    .C_50Mhz(clk), .rst_n(rst_n), .C_1Hz(c1hz), .start(start), .pause(pause),
    .clear(clear), .preset(preset), .bcd(bcd), .state_o(state_o), .done(done), .alarm(alarm)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int preset_secs(input logic [15:0] p);
    int d3 = int'(p[15:12]), d2 = int'(p[11:8]), d1 = int'(p[7:4]), d0 = int'(p[3:0]);
    return ((d3 > 5 ? 5 : d3) * 10 + (d2 > 9 ? 9 : d2)) * 60 + (d1 > 5 ? 5 : d1) * 10 + (d0 > 9 ? 9 : d0);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m = s / 60, x = s % 60;
    return 16'((m / 10) * 4096 + (m % 10) * 256 + (x / 10) * 16 + x % 10);
  endfunction

  // A C_1Hz rise first sampled at edge k is acted on at edge k+2.
  task automatic model_step();
    bit tk = hist[1] & ~hist[2];
    int ps = preset_secs(preset);
    hist   = {hist[1:0], c1hz};
    m_done = 1'b0;
    if (clear) begin
      m_st = 0; m_secs = ps;
    end else if (start && m_st == 2) begin
      m_st = 1;
    end else if (start && m_st != 1) begin
      m_secs = ps; m_st = ps == 0 ? 3 : 1; m_done = ps == 0;
    end else if (pause && m_st == 1) begin
      m_st = 2;
    end else if (tk && m_st == 1) begin
      m_secs--;
      if (m_secs == 0) begin m_st = 3; m_done = 1'b1; end
    end else if (m_st == 0) begin
      m_secs = ps;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (done) done_cnt++;
    check("bcd", bcd, to_bcd(m_secs));
    check("state", 16'(state_o), 16'(m_st));
    check("done", 16'(done), 16'(m_done));
    check("alarm", 16'(alarm), 16'(m_st == 3));
  endtask

  task automatic do_reset();
    #4 rst_n = 1'b0;
    c1hz = 1'b0;
    #1;
    check("rst_bcd", bcd, 16'h0000);
    check("rst_state", 16'(state_o), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    check("rst_alarm", 16'(alarm), 16'h0000);
    hist = 3'b000; m_secs = 0; m_st = 0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic cmd(input bit s, input bit p, input bit c);
    start = s; pause = p; clear = c;
    cycle();
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic hz_period(input int hi, input int lo);
    c1hz = 1'b1;
    repeat (hi) cycle();
    c1hz = 1'b0;
    repeat (lo) cycle();
  endtask

  // Issue start/pause on exactly the cycle the tick is live.
  task automatic hz_cmd(input bit s, input bit p);
    c1hz = 1'b1;
    cycle();
    cycle();
    cmd(s, p, 1'b0);
    cycle();
    c1hz = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic rcycle();
    int r = int'($urandom_range(0, 31));
    if ($urandom_range(0, 63) == 0)
      preset = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 20));
    start = r == 0 || r == 4 || r == 5;
    pause = r == 1 || r == 4;
    clear = r == 3 || r == 5;
    cycle();
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int d0, n;
    do_reset();
    preset = 16'h0003;
    cycle();
    d0 = done_cnt;
    cmd(1, 0, 0);
    repeat (3) hz_period(4, 4);
    check("tp1_bcd", bcd, 16'h0000);
    check("tp1_state", 16'(state_o), 16'h0003);
    check("tp1_alarm", 16'(alarm), 16'h0001);
    check("tp1_done_cnt", 16'(done_cnt - d0), 16'h0001);

    cmd(0, 0, 1);
    preset = 16'h0100;
    cmd(1, 0, 0);
    hz_period(4, 4);
    check("borrow_0100", bcd, 16'h0059);
    cmd(0, 0, 1);
    preset = 16'h1000;
    cmd(1, 0, 0);
    hz_period(4, 4);
    check("borrow_1000", bcd, 16'h0959);

    cmd(0, 0, 1);
    preset = 16'h7A9C;
    cycle();
    cycle();
    check("sanitize_idle", bcd, 16'h5959);
    cmd(1, 0, 0);
    hz_period(4, 4);
    check("sanitize_run", bcd, 16'h5958);

    cmd(0, 0, 1);
    preset = 16'h0010;
    cmd(1, 0, 0);
    hz_cmd(0, 1);
    repeat (3) hz_period(4, 4);
    check("pause_hold", bcd, 16'h0010);
    check("pause_state", 16'(state_o), 16'h0002);
    hz_cmd(1, 0);
    check("resume_drop", bcd, 16'h0010);
    check("resume_state", 16'(state_o), 16'h0001);
    hz_period(4, 4);
    check("resume_tick", bcd, 16'h0009);

    cmd(0, 0, 1);
    preset = 16'h0000;
    cycle();
    cmd(1, 0, 0);
    check("zero_state", 16'(state_o), 16'h0003);
    check("zero_done", 16'(done), 16'h0001);
    cmd(1, 0, 1);
    check("clr_start_state", 16'(state_o), 16'h0000);
    check("clr_start_alarm", 16'(alarm), 16'h0000);

    preset = 16'h0042;
    cycle();
    cmd(1, 0, 0);
    d0 = done_cnt;
    cycle();
    check("pre_rst_bcd", bcd, 16'h0042);
    do_reset();
    repeat (4) cycle();
    check("rst_no_done", 16'(done_cnt - d0), 16'h0000);

    cmd(1, 0, 0);
    c1hz = 1'b1;
    n = 0;
    while (bcd == 16'h0042 && n < 10) begin
      cycle();
      n++;
    end
    check("latency", 16'(n), 16'h0003);
    c1hz = 1'b0;
    repeat (4) cycle();

    repeat (400) begin
      int hi = int'($urandom_range(1, 6)), lo = int'($urandom_range(1, 6));
      c1hz = 1'b1;
      repeat (hi) rcycle();
      c1hz = 1'b0;
      repeat (lo) rcycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Minutes:seconds countdown timer that consumes the 1 Hz square wave produced by the frequency divider. It sits directly downstream of the divider. C_1Hz is synchronised into the C_50Mhz domain and its rising edge becomes a one-cycle tick. A four-digit BCD count (mm:ss, max 59:59) is decremented on each tick under start/pause/clear control. The block drives BCD digits and, optionally, four seven-segment displays.

Parameters:
SYNC_STAGES, 2, flip-flops in the C_1Hz synchroniser; legal values >= 2.
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default); 0 = active-high.

Ports:
C_50Mhz  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous, active-low reset.
C_1Hz  in  1  1 Hz square wave from the divider; asynchronous to this block's logic, rising edge once per second.
start  in  1  single-cycle pulse, synchronous to C_50Mhz (debounced upstream).
pause  in  1  single-cycle pulse, synchronous.
clear  in  1  single-cycle pulse, synchronous.
preset  in  16  BCD {min10, min1, sec10, sec1}.
bcd  out  16  current count, BCD {min10, min1, sec10, sec1}.
state_o  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE.
done  out  1  one-cycle pulse when the count reaches 00:00.
alarm  out  1  level; high while in DONE.
seg3..seg0  out  7 each  segments {g..a}; seg3 = min10. Present only with SEVEN_SEG_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; bcd = 16'h0000; done = 0; alarm = 0.
  - Synchroniser flops and edge register cleared to 0.
  - Segments show blank: all off, per SEG_ACTIVE_LOW.
  - Reset mid-count aborts the count with no done pulse.
- Tick generation:
  - C_1Hz passes through SYNC_STAGES flops, then a previous-value register.
  - tick = sync_out & ~prev.
  - With default SYNC_STAGES = 2, bcd changes on the 3rd C_50Mhz rising edge after C_1Hz rises.
  - Falling edges of C_1Hz are ignored.
  - Exactly one tick per C_1Hz period.
- Preset sanitising, applied when the preset is loaded:
  - Any digit > 9 is treated as 9.
  - min10 or sec10 > 5 is treated as 5.
- Command priority within a cycle: clear > start > pause > tick.
- IDLE:
  - bcd continuously shows the sanitised preset.
  - start with nonzero preset -> load preset, go to RUN.
  - start with preset = 00:00 -> go to DONE; done pulses.
  - pause and tick have no effect.
- RUN:
  - tick -> decrement bcd.
  - tick when bcd = 00:01 -> bcd = 00:00, go to DONE, done = 1 for that one cycle.
  - pause -> PAUSED; a tick in the same cycle is dropped.
  - clear -> IDLE.
  - start is ignored.
- PAUSED:
  - bcd holds; ticks are dropped.
  - start -> RUN; a tick in the same cycle is dropped.
  - clear -> IDLE.
- DONE:
  - bcd holds 00:00; alarm = 1.
  - clear -> IDLE.
  - start -> reload preset and go to RUN (same rules as in IDLE).
- BCD decrement, with borrow chain:
  - sec1 0 -> 9 and borrows from sec10.
  - sec10 0 -> 5 and borrows from min1.
  - min1 0 -> 9 and borrows from min10.
  - min10 0 -> 0 with no underflow; unreachable because DONE is entered at 00:01.
- done is registered.
- All outputs are registered except the seven-segment decode, which is combinational from bcd.

Optional Feature:
SEVEN_SEG_EN
- Defined:
  - Four BCD-to-7-segment decoders drive seg3..seg0.
  - Digits 0-9 use the standard patterns; codes A-F show blank.
  - In DONE, all four displays blink at 1 Hz, gated by the synchronised C_1Hz level.
  - Polarity follows SEG_ACTIVE_LOW.
- Undefined:
  - seg ports are absent; only bcd, state_o, done and alarm exist.
  - No blink logic.

Test Plan:
- Reset, then preset = 16'h0003, start, apply 3 C_1Hz periods -> bcd goes 0003, 0002, 0001, 0000; done pulses once, 1 cycle wide; state_o = 11; alarm = 1.
- Preset = 16'h0100, start, 1 tick -> bcd = 16'h0059 (borrow chain). Preset = 16'h1000, 1 tick -> bcd = 16'h0959.
- Preset = 16'h7A9C -> IDLE bcd reads 16'h5959; start, 1 tick -> bcd = 16'h5958.
- RUN at 0010, pause issued in the same cycle as a tick -> bcd stays 0010 through 3 ticks. Then start in the same cycle as a tick -> still 0010; next tick -> 0009.
- Preset = 0000, start -> DONE in 1 cycle with done pulse. clear and start in the same cycle -> IDLE, alarm = 0.
- Assert rst_n low mid-RUN at bcd = 0042 -> immediately bcd = 0000, state_o = 00, done never pulses. Measure the C_1Hz rising edge to bcd change: exactly 3 clock edges.
